ahb_apb3_bridge: RTL and testbench
==================================

AHB_APB3_BRIDGE -- requirements
Module: ahb_apb3_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AHB/APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning AHB/APB address width.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, meaning number of APB slaves, 1..16.
REQ-004 SHALL have parameter SEL_BITS, default 4, meaning HADDR MSBs used for slave decode.
REQ-005 SHALL have parameter TIMEOUT, default 16, meaning maximum ACCESS cycles without PREADY.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 SHALL have these ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous active-high reset
HSEL  in  1  bridge selected
HTRANS  in  2  AHB transfer type; NONSEQ=2, SEQ=3 valid
HWRITE  in  1  1=write
HADDR  in  ADDR_WIDTH  address
HWDATA  in  DATA_WIDTH  write data, valid one cycle after address phase
HREADY  in  1  bus ready
HREADYOUT  out  1  bridge ready
HRESP  out  1  1=ERROR
HRDATA  out  DATA_WIDTH  read data
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB access phase
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave i read data in bits [i*DATA_WIDTH +: DATA_WIDTH]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Function
REQ-008 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] in state IDLE or ERR2; otherwise it SHALL ignore AHB inputs.
REQ-009 SHALL register HADDR, HWRITE and slave index = HADDR[ADDR_WIDTH-1 -: SEL_BITS] on acceptance.
REQ-010 SHALL implement states IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
REQ-011 Accept: index >= NUM_SLAVES -> ERR1 (decode error, no PSEL); write -> WWAIT; read -> SETUP.
REQ-012 WWAIT SHALL capture HWDATA into PWDATA and go to SETUP.
REQ-013 SETUP SHALL drive PSEL[index]=1, PENABLE=0, PADDR and PWRITE from the registered values, and go to ACCESS.
REQ-014 ACCESS SHALL drive PSEL[index]=1 and PENABLE=1, and hold PADDR, PWRITE and PWDATA stable.
REQ-015 ACCESS exit SHALL be:
- PREADY[index] & ~PSLVERR[index] -> IDLE, with HRDATA <= PRDATA slice on reads.
- PREADY[index] & PSLVERR[index] -> ERR1.
- otherwise stay in ACCESS.
REQ-016 A wait counter SHALL clear on SETUP and increment each ACCESS cycle with PREADY low; when it reaches TIMEOUT-1, the bridge SHALL go to ERR1 and drop PSEL/PENABLE.
REQ-017 HREADYOUT SHALL be 1 in IDLE and ERR2, and 0 in WWAIT, SETUP, ACCESS and ERR1.
REQ-018 HRESP SHALL be 1 in ERR1 and ERR2, and 0 elsewhere.
REQ-019 ERR1 -> ERR2 -> IDLE unconditionally (two-cycle AHB error response); ERR2 may accept a new transfer per REQ-008.
REQ-020 HRDATA SHALL hold its last value on writes and on errors.
REQ-021 Latency from address phase to HREADYOUT=1 (PREADY immediate) SHALL be 3 cycles for reads and 4 for writes.
REQ-022 At most one PSEL bit SHALL be high at any time; PENABLE=1 SHALL imply exactly one PSEL bit high.

Reset
REQ-023 On HRESET=1, asynchronously and regardless of state:
- state=IDLE, wait counter=0
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0
- HREADYOUT=1, HRESP=0
REQ-024 Reset mid-transfer SHALL abandon the transfer; the first accept after release SHALL behave as from a clean IDLE.

Verification
REQ-025 Read slave 2, HADDR=0x2010, PRDATA[2]=0xCAFEF00D, PREADY immediate -> PSEL=0100 one cycle with PENABLE=0, then one cycle with PENABLE=1; HRDATA=0xCAFEF00D with HREADYOUT=1 at cycle 3.
REQ-026 Write HADDR=0x0004, HWDATA=0x12345678, PREADY[0] after 3 wait cycles -> PWDATA=0x12345678 stable from SETUP; ACCESS lasts 4 cycles; HRESP=0.
REQ-027 Read slave 1 with PSLVERR[1]=1 at PREADY -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1; HRDATA unchanged.
REQ-028 HADDR=0x5000 with NUM_SLAVES=4 -> PSEL stays 0; ERR1 then ERR2 immediately follow acceptance.
REQ-029 PREADY held low for 16 ACCESS cycles -> PSEL/PENABLE drop; two-cycle error response follows.
REQ-030 HRESET pulsed during ACCESS, then back-to-back NONSEQ read/write (second accepted in ERR2 or IDLE) -> outputs at reset values immediately; subsequent transfers complete correctly.

Source files
------------

// File: rtl/ahb_apb3_bridge.sv
// AHB-Lite to APB3 bridge: one outstanding transfer, per-slave decode on HADDR MSBs,
// two-cycle AHB error response for decode errors, PSLVERR and PREADY timeouts.
module ahb_apb3_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_BITS   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic                           HSEL,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [DATA_WIDTH-1:0]          HWDATA,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic                           HRESP,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR,
  output logic [2:0]                     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_e;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [SEL_BITS-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic [CW-1:0]         wait_q, wait_d;

  logic                  accept;
  logic [SEL_BITS-1:0]   haddr_idx;
  logic                  decode_err;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  unused_htrans0;

  // Valid/ready: a transfer is taken only when the bus is selected, ready and
  // HTRANS is NONSEQ/SEQ, and only while the bridge itself reports HREADYOUT=1.
  assign accept         = HSEL & HREADY & HTRANS[1];
  assign haddr_idx      = HADDR[ADDR_WIDTH-1 -: SEL_BITS];
  assign decode_err     = 32'(haddr_idx) >= 32'(NUM_SLAVES);
  assign unused_htrans0 = HTRANS[0];

  // Mux the addressed slave's response; an out-of-range index reads as idle.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (32'(idx_q) == 32'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          idx_d   = haddr_idx;
          if (decode_err)  state_d = S_ERR1;
          else if (HWRITE) state_d = S_WWAIT;
          else             state_d = S_SETUP;
        end
      end
      S_WWAIT: begin
        pwdata_d = HWDATA;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        wait_d  = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_IDLE;
            if (!write_q) hrdata_d = sel_rdata;
          end
        end else if (wait_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ERR1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      wait_q   <= wait_d;
    end
  end

  // APB outputs decode straight from state so PSEL is one-hot only in SETUP/ACCESS.
  always_comb begin
    PSEL = '0;
    if (state_q == S_SETUP || state_q == S_ACCESS) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        PSEL[i] = (32'(idx_q) == 32'(i));
      end
    end
  end

  assign PENABLE   = (state_q == S_ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = pwdata_q;
  assign HRDATA    = hrdata_q;
  assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_apb3_bridge.sv
// Directed bench for ahb_apb3_bridge: read/write latency, wait states, slave error,
// decode error, PREADY timeout and asynchronous reset mid-transfer.
module tb_ahb_apb3_bridge;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NS = 4;

  logic          clk;
  logic          rst;
  logic          hsel;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic [AW-1:0] paddr;
  logic [NS-1:0] psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0] pready;
  logic [NS-1:0] pslverr;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;

  ahb_apb3_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .SEL_BITS(4), .TIMEOUT(16)
  ) dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HTRANS(htrans), .HWRITE(hwrite),
    .HADDR(haddr), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hreadyout),
    .HRESP(hresp), .HRDATA(hrdata), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: one-cycle AHB address phase, then bus returns to IDLE.
  task automatic addr_phase(input logic wr, input logic [AW-1:0] a);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = a;
    tick();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_psel"},   32'(psel),      32'h0);
    chk({tag, "_pen"},    32'(penable),   32'h0);
    chk({tag, "_paddr"},  32'(paddr),     32'h0);
    chk({tag, "_pwdata"}, 32'(pwdata),    32'h0);
    chk({tag, "_pwrite"}, 32'(pwrite),    32'h0);
    chk({tag, "_hrdata"}, 32'(hrdata),    32'h0);
    chk({tag, "_hrdyo"},  32'(hreadyout), 32'h1);
    chk({tag, "_hresp"},  32'(hresp),     32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
    hwdata = '0; hready = 1'b1; prdata = '0; pready = '0; pslverr = '0;
    last_rd = '0;
    #12;
    check_reset_outputs("rst");
    chk("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    tick();

    // Read slave 2, PREADY immediate: SETUP, ACCESS, then IDLE with data at cycle 3.
    prdata[2*DW +: DW] = 32'hCAFEF00D;
    pready = 4'b1111;
    exp_q.push_back(32'hCAFEF00D);
    addr_phase(1'b0, 16'h2010);
    chk("rd_setup_psel", 32'(psel), 32'h4);
    chk("rd_setup_pen", 32'(penable), 32'h0);
    chk("rd_setup_paddr", 32'(paddr), 32'h2010);
    chk("rd_setup_pwrite", 32'(pwrite), 32'h0);
    chk("rd_setup_hrdyo", 32'(hreadyout), 32'h0);
    tick();
    chk("rd_access_psel", 32'(psel), 32'h4);
    chk("rd_access_pen", 32'(penable), 32'h1);
    tick();
    chk("rd_done_hrdyo", 32'(hreadyout), 32'h1);
    chk("rd_done_psel", 32'(psel), 32'h0);
    last_rd = exp_q.pop_front();
    chk("rd_done_hrdata", 32'(hrdata), last_rd);

    // Write slave 0 with three wait states: ACCESS lasts four cycles.
    pready = 4'b0000;
    addr_phase(1'b1, 16'h0004);
    hwdata = 32'h12345678;
    chk("wr_wwait_hrdyo", 32'(hreadyout), 32'h0);
    chk("wr_wwait_psel", 32'(psel), 32'h0);
    tick();
    hwdata = 32'hFFFFFFFF;
    chk("wr_setup_psel", 32'(psel), 32'h1);
    chk("wr_setup_pen", 32'(penable), 32'h0);
    chk("wr_setup_pwdata", 32'(pwdata), 32'h12345678);
    chk("wr_setup_pwrite", 32'(pwrite), 32'h1);
    chk("wr_setup_paddr", 32'(paddr), 32'h0004);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("wr_access_pen", 32'(penable), 32'h1);
      chk("wr_access_pwdata", 32'(pwdata), 32'h12345678);
      chk("wr_access_hresp", 32'(hresp), 32'h0);
      if (c == 3) pready = 4'b0001;
      tick();
    end
    pready = 4'b0000;
    chk("wr_done_pen", 32'(penable), 32'h0);
    chk("wr_done_hrdyo", 32'(hreadyout), 32'h1);
    chk("wr_done_hresp", 32'(hresp), 32'h0);
    chk("wr_hrdata_hold", 32'(hrdata), last_rd);

    // Read slave 1 with PSLVERR: two-cycle error response, HRDATA unchanged.
    prdata[1*DW +: DW] = 32'hDEADBEEF;
    pready = 4'b0010;
    pslverr = 4'b0010;
    addr_phase(1'b0, 16'h1000);
    chk("slverr_setup_psel", 32'(psel), 32'h2);
    tick();
    tick();
    chk("slverr_err1_hresp", 32'(hresp), 32'h1);
    chk("slverr_err1_hrdyo", 32'(hreadyout), 32'h0);
    chk("slverr_err1_psel", 32'(psel), 32'h0);
    tick();
    chk("slverr_err2_hresp", 32'(hresp), 32'h1);
    chk("slverr_err2_hrdyo", 32'(hreadyout), 32'h1);
    tick();
    chk("slverr_idle_hresp", 32'(hresp), 32'h0);
    chk("slverr_hrdata_hold", 32'(hrdata), last_rd);
    pready = 4'b0000;
    pslverr = 4'b0000;

    // Decode error: index 5 with four slaves.
    addr_phase(1'b0, 16'h5000);
    chk("dec_err1_psel", 32'(psel), 32'h0);
    chk("dec_err1_hresp", 32'(hresp), 32'h1);
    chk("dec_err1_hrdyo", 32'(hreadyout), 32'h0);
    tick();
    chk("dec_err2_hresp", 32'(hresp), 32'h1);
    chk("dec_err2_hrdyo", 32'(hreadyout), 32'h1);
    chk("dec_err2_psel", 32'(psel), 32'h0);
    tick();
    chk("dec_idle_hresp", 32'(hresp), 32'h0);

    // PREADY never rises: ACCESS is abandoned after 16 cycles.
    addr_phase(1'b0, 16'h3000);
    chk("to_setup_psel", 32'(psel), 32'h8);
    tick();
    n = 0;
    while (penable && n < 40) begin
      n++;
      tick();
    end
    chk("to_access_cycles", 32'(n), 32'd16);
    chk("to_err1_psel", 32'(psel), 32'h0);
    chk("to_err1_hresp", 32'(hresp), 32'h1);
    tick();
    chk("to_err2_hresp", 32'(hresp), 32'h1);
    chk("to_err2_hrdyo", 32'(hreadyout), 32'h1);
    tick();
    chk("to_hrdata_hold", 32'(hrdata), last_rd);

    // Asynchronous reset during ACCESS.
    addr_phase(1'b0, 16'h0020);
    tick();
    chk("rstmid_access_pen", 32'(penable), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    #1 rst = 1'b0;
    tick();
    last_rd = '0;

    // Decode error, then a read accepted in ERR2, then a back-to-back write.
    pready = 4'b1111;
    prdata[2*DW +: DW] = 32'h11223344;
    exp_q.push_back(32'h11223344);
    addr_phase(1'b0, 16'h6000);
    chk("b2b_err1_hresp", 32'(hresp), 32'h1);
    tick();
    chk("b2b_err2_hrdyo", 32'(hreadyout), 32'h1);
    addr_phase(1'b0, 16'h2020);
    chk("b2b_rd_setup_psel", 32'(psel), 32'h4);
    chk("b2b_rd_setup_paddr", 32'(paddr), 32'h2020);
    tick();
    tick();
    chk("b2b_rd_hrdyo", 32'(hreadyout), 32'h1);
    last_rd = exp_q.pop_front();
    chk("b2b_rd_hrdata", 32'(hrdata), last_rd);
    addr_phase(1'b1, 16'h0008);
    hwdata = 32'hA5A5A5A5;
    tick();
    hwdata = '0;
    chk("b2b_wr_setup_psel", 32'(psel), 32'h1);
    chk("b2b_wr_setup_pwdata", 32'(pwdata), 32'hA5A5A5A5);
    tick();
    chk("b2b_wr_access_pen", 32'(penable), 32'h1);
    tick();
    chk("b2b_wr_done_hrdyo", 32'(hreadyout), 32'h1);
    chk("b2b_wr_hrdata_hold", 32'(hrdata), last_rd);
    chk("b2b_exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
